bpu_btb: RTL and testbench
==========================

Name: bpu_btb

Overview:
- Branch prediction unit for the 5-stage RV32 pipeline, sitting beside the IF-stage PC.
- Replaces the fixed "predict PC+4, flush on EX resolve" policy with a direct-mapped branch target buffer plus per-entry saturating direction counters.
- Predicts combinationally in IF from the current PC, and is trained by the resolved control instruction in EX.
- Reports mispredict and redirect PC to the hazard logic, and keeps saturating performance counters for the PDU debug bus.

Parameters:
- ENTRIES, 16: BTB depth; power of two, ≥2; IDX_W = log2(ENTRIES).
- CNT_W, 2: direction counter width, 1..4.
- XLEN, 32: address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_pc  in  XLEN  current IF-stage PC.
- pred_hit  out  1  valid entry with matching tag for if_pc.
- pred_taken  out  1  predict redirect.
- pred_target  out  XLEN  predicted target; 0 when pred_hit=0.
- upd_valid  in  1  EX holds a resolved branch/jal/jalr this cycle; already gated by the caller with !stall_ex and !flush.
- upd_pc  in  XLEN  PC of the EX instruction.
- upd_type  in  2  0=cond branch, 1=jal, 2=jalr, 3=reserved (treated as no-op).
- upd_taken  in  1  actual outcome; 1 for jal/jalr.
- upd_target  in  XLEN  actual target.
- upd_pred_taken  in  1  prediction carried down the pipeline with the instruction.
- upd_pred_target  in  XLEN  predicted target carried down the pipeline.
- clear  in  1  synchronous invalidate of all entries.
- mispredict  out  1  combinational; EX must flush IF/ID and ID/EX.
- redirect_pc  out  XLEN  combinational correct next PC.
- stat_ctrl  out  32  count of trained control instructions.
- stat_miss  out  32  count of mispredicts.

Behaviour:
- Index and tag:
  - idx = pc[IDX_W+1:2].
  - tag = pc[XLEN-1:IDX_W+2].
  - pc[1:0] is ignored.
- Entry fields: valid, tag, target[XLEN], is_jal, cnt[CNT_W].
- Prediction (0-cycle, combinational read):
  - pred_hit = valid[idx] && tag match.
  - pred_taken = pred_hit && (is_jal || cnt MSB==1).
  - pred_target = pred_hit ? target : 0.
- Training (on the rising edge when upd_valid):
  - Cond branch, hit: cnt increments if taken, decrements otherwise, saturating at 0 and 2^CNT_W-1. Target is overwritten only when taken.
  - Cond branch, miss, taken: allocate (overwrite any occupant). valid=1, tag, target, is_jal=0, cnt=2^(CNT_W-1) (weakly taken).
  - Cond branch, miss, not-taken: no allocation.
  - jal: allocate or overwrite, with is_jal=1 and cnt unchanged/weakly taken.
  - jalr: never allocated. If a jalr hits (aliasing), that entry is invalidated.
  - type 3: no table change and no stat change; mispredict is forced to 0.
- Mispredict:
  - mispredict = upd_valid && type≠3 && (upd_taken≠upd_pred_taken || (upd_taken && upd_target≠upd_pred_target)).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4, with the add wrapping modulo 2^XLEN.
- Statistics:
  - stat_ctrl increments on every trained update.
  - stat_miss increments when mispredict=1.
  - Both saturate at 32'hFFFFFFFF and never wrap.
- Simultaneous read/write to the same index: IF sees the pre-update contents; no bypass.
- clear vs update in the same cycle: clear wins; all valid bits go to 0 and the update is discarded. Stats are kept.
- Reset (asynchronous, any time, including mid-update):
  - All valid=0, cnt=2^(CNT_W-1)-1 (weakly not-taken), stats=0.
  - Outputs go immediately to pred_hit=0, pred_taken=0, pred_target=0, stat_*=0.
  - mispredict and redirect_pc follow their inputs.
- CNT_W=1: cnt is the last outcome (0/1); weakly taken = 1 and weakly not-taken = 0.

Decomposition:
- Shared package cpu_pkg holds:
  - XLEN.
  - Branch-type encodings BR_COND/BR_JAL/BR_JALR/BR_NONE.
  - Counter init constants CNT_WT/CNT_WNT as functions of CNT_W.
  - The btb_entry_t struct.
- One sub-module: sat_counter (CNT_W-bit up/down saturating next-value logic), instantiated per update path.

Test Plan:
- Reset, then if_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0, stat_ctrl=0.
- Cond branch at 0x100, taken to 0x80, upd_pred_taken=0 -> mispredict=1, redirect_pc=0x80, stat_miss=1. Next cycle if_pc=0x100 -> pred_hit=1, pred_taken=1, pred_target=0x80.
- Same branch not-taken twice with CNT_W=2 -> cnt 2→1→0, pred_taken=0. Two more not-taken -> cnt stays 0, redirect_pc=0x104.
- Alias with ENTRIES=16: 0x100 and 0x140 share idx 0. jal at 0x140 allocates -> if_pc=0x100 misses and if_pc=0x140 hits with is_jal (pred_taken=1). jalr update at 0x140 -> entry invalidated.
- upd_valid and clear in the same cycle, and async reset asserted mid-stream -> all subsequent lookups miss. After reset, stats=0; after clear alone, stats unchanged.
- Force 2^32 mispredicts via a preloaded counter -> stat_miss holds 0xFFFFFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the branch prediction unit: address width, branch-type
// encodings, direction-counter init values and the BTB entry layout.
package cpu_pkg;

  localparam int XLEN      = 32;
  localparam int CNT_MAX_W = 4;

  localparam logic [1:0] BR_COND = 2'd0;
  localparam logic [1:0] BR_JAL  = 2'd1;
  localparam logic [1:0] BR_JALR = 2'd2;
  localparam logic [1:0] BR_NONE = 2'd3;

  // Weakly-taken: MSB set, all lower bits clear.
  function automatic logic [CNT_MAX_W-1:0] cnt_wt(input int cnt_w);
    return CNT_MAX_W'(1 << (cnt_w - 1));
  endfunction

  // Weakly-not-taken: one below weakly-taken.
  function automatic logic [CNT_MAX_W-1:0] cnt_wnt(input int cnt_w);
    return CNT_MAX_W'((1 << (cnt_w - 1)) - 1);
  endfunction

  // Counter is stored at the widest legal width; only the low CNT_W bits are ever non-zero.
  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      tag;
    logic [XLEN-1:0]      target;
    logic                 is_jal;
    logic [CNT_MAX_W-1:0] cnt;
  } btb_entry_t;

endpackage

// File: rtl/bpu_btb_sat_counter.sv
// Up/down saturating next-value logic for a CNT_W-bit direction counter
// carried in a CNT_MAX_W-bit field.
module sat_counter
  import cpu_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic [CNT_MAX_W-1:0] cnt,
  input  logic                 inc,
  output logic [CNT_MAX_W-1:0] cnt_next
);

  localparam logic [CNT_MAX_W-1:0] CNT_MAX = CNT_MAX_W'((1 << CNT_W) - 1);

  // Step toward taken or not-taken, clamping at either end.
  always_comb begin
    cnt_next = cnt;
    if (inc) begin
      if (cnt >= CNT_MAX) begin
        cnt_next = CNT_MAX;
      end else begin
        cnt_next = cnt + 4'd1;
      end
    end else begin
      if (cnt == 4'd0) begin
        cnt_next = 4'd0;
      end else begin
        cnt_next = cnt - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bpu_btb.sv
// Direct-mapped branch target buffer with per-entry direction counters: predicts
// combinationally from the IF PC, trains from the resolved EX control instruction.
module bpu_btb
  import cpu_pkg::*;
#(
  parameter int          ENTRIES  = 16,
  parameter int          CNT_W    = 2,
  parameter int          XLEN     = cpu_pkg::XLEN,
  parameter logic [31:0] STAT_RST = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [1:0]      upd_type,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  input  logic            clear,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     stat_ctrl,
  output logic [31:0]     stat_miss
);

  localparam int                   IDX_W   = $clog2(ENTRIES);
  localparam logic [CNT_MAX_W-1:0] CNT_WT  = cnt_wt(CNT_W);
  localparam logic [CNT_MAX_W-1:0] CNT_WNT = cnt_wnt(CNT_W);
  localparam logic [31:0]          STAT_MAX = 32'hFFFF_FFFF;

  btb_entry_t            table_r [ENTRIES];
  btb_entry_t            if_entry_s;
  logic [IDX_W-1:0]      if_idx_s;
  logic [IDX_W-1:0]      upd_idx_s;
  logic [XLEN-1:0]       if_tag_s;
  logic [XLEN-1:0]       upd_tag_s;
  logic                  upd_hit_s;
  logic                  train_s;
  logic                  misp_s;
  logic [CNT_MAX_W-1:0]  cnt_next_s;
  logic [31:0]           stat_ctrl_r;
  logic [31:0]           stat_miss_r;
  logic                  unused_s;

  // Byte offset within the instruction word never selects an entry.
  assign unused_s  = ^if_pc[1:0];

  assign if_idx_s  = if_pc[IDX_W+1:2];
  assign if_tag_s  = if_pc >> (IDX_W + 2);
  assign upd_idx_s = upd_pc[IDX_W+1:2];
  assign upd_tag_s = upd_pc >> (IDX_W + 2);

  assign if_entry_s = table_r[if_idx_s];
  assign upd_hit_s  = table_r[upd_idx_s].valid && (table_r[upd_idx_s].tag == upd_tag_s);
  assign train_s    = upd_valid && (upd_type != BR_NONE);

  sat_counter #(.CNT_W(CNT_W)) u_dir_cnt (
    .cnt      (table_r[upd_idx_s].cnt),
    .inc      (upd_taken),
    .cnt_next (cnt_next_s)
  );

  // Zero-cycle lookup; the table read reflects state before any same-cycle update.
  always_comb begin
    pred_hit    = 1'b0;
    pred_taken  = 1'b0;
    pred_target = {XLEN{1'b0}};
    if (if_entry_s.valid && (if_entry_s.tag == if_tag_s)) begin
      pred_hit    = 1'b1;
      pred_taken  = if_entry_s.is_jal || (if_entry_s.cnt >= CNT_WT);
      pred_target = if_entry_s.target;
    end else begin
      pred_hit    = 1'b0;
      pred_taken  = 1'b0;
      pred_target = {XLEN{1'b0}};
    end
  end

  // Resolve the EX instruction against the prediction it carried down the pipe.
  always_comb begin
    misp_s      = 1'b0;
    redirect_pc = upd_pc + 32'd4;
    if (upd_taken) begin
      redirect_pc = upd_target;
    end else begin
      redirect_pc = upd_pc + 32'd4;
    end
    if (train_s) begin
      misp_s = (upd_taken != upd_pred_taken) ||
               (upd_taken && (upd_target != upd_pred_target));
    end else begin
      misp_s = 1'b0;
    end
  end

  assign mispredict = misp_s;

  // Table state: clear beats a same-cycle update; jalr hits are treated as aliases and dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_r[i] <= '{valid: 1'b0, tag: {XLEN{1'b0}}, target: {XLEN{1'b0}},
                        is_jal: 1'b0, cnt: CNT_WNT};
      end
    end else if (clear) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_r[i].valid <= 1'b0;
      end
    end else if (train_s) begin
      case (upd_type)
        BR_COND: begin
          if (upd_hit_s) begin
            table_r[upd_idx_s].cnt <= cnt_next_s;
            if (upd_taken) begin
              table_r[upd_idx_s].target <= upd_target;
            end
          end else if (upd_taken) begin
            table_r[upd_idx_s] <= '{valid: 1'b1, tag: upd_tag_s, target: upd_target,
                                    is_jal: 1'b0, cnt: CNT_WT};
          end
        end
        BR_JAL: begin
          table_r[upd_idx_s] <= '{valid: 1'b1, tag: upd_tag_s, target: upd_target,
                                  is_jal: 1'b1,
                                  cnt: upd_hit_s ? table_r[upd_idx_s].cnt : CNT_WT};
        end
        BR_JALR: begin
          if (upd_hit_s) begin
            table_r[upd_idx_s].valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Performance counters stick at all-ones instead of wrapping; clear leaves them alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_ctrl_r <= STAT_RST;
      stat_miss_r <= STAT_RST;
    end else begin
      if (train_s && (stat_ctrl_r != STAT_MAX)) begin
        stat_ctrl_r <= stat_ctrl_r + 32'd1;
      end
      if (misp_s && (stat_miss_r != STAT_MAX)) begin
        stat_miss_r <= stat_miss_r + 32'd1;
      end
    end
  end

  assign stat_ctrl = stat_ctrl_r;
  assign stat_miss = stat_miss_r;

endmodule

// File: tb/tb_bpu_btb.sv
// Directed scoreboard bench for bpu_btb: stimulus queues expected values per cycle,
// a negedge monitor pops and compares them.
module tb_bpu_btb;

  localparam int S_HIT = 0, S_TAKEN = 1, S_TARGET = 2, S_MISP = 3, S_REDIR = 4,
                 S_CTRL = 5, S_MISS = 6, S_SAT_CTRL = 7, S_SAT_MISS = 8;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] if_pc = 32'h0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = 32'h0;
  logic [1:0]  upd_type = 2'd0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = 32'h0;
  logic        upd_pred_taken = 1'b0;
  logic [31:0] upd_pred_target = 32'h0;
  logic        clear = 1'b0;

  logic        pred_hit, pred_taken, mispredict;
  logic [31:0] pred_target, redirect_pc, stat_ctrl, stat_miss;
  logic        s_hit, s_taken, s_misp;
  logic [31:0] s_target, s_redir, s_ctrl, s_miss;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  bpu_btb dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_type(upd_type),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .clear(clear), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_ctrl(stat_ctrl), .stat_miss(stat_miss)
  );

  // Second instance with stats preloaded near the top to reach saturation quickly.
  bpu_btb #(.STAT_RST(32'hFFFF_FFFE)) u_sat (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_hit(s_hit), .pred_taken(s_taken), .pred_target(s_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_type(upd_type),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .clear(clear), .mispredict(s_misp), .redirect_pc(s_redir),
    .stat_ctrl(s_ctrl), .stat_miss(s_miss)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] get_sig(input int sig);
    case (sig)
      S_HIT:      return {31'd0, pred_hit};
      S_TAKEN:    return {31'd0, pred_taken};
      S_TARGET:   return pred_target;
      S_MISP:     return {31'd0, mispredict};
      S_REDIR:    return redirect_pc;
      S_CTRL:     return stat_ctrl;
      S_MISS:     return stat_miss;
      S_SAT_CTRL: return s_ctrl;
      S_SAT_MISS: return s_miss;
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compare every expectation scheduled for this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] act;
      e = exp_q.pop_front();
      act = get_sig(e.sig);
      n_tests++;
      if (e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: not sampled in its cycle (got %h, want %h)", e.name, act, e.val);
      end else if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h, want %h", e.name, act, e.val);
      end
    end
  end

  task automatic chk(input string name, input int sig, input logic [31:0] val);
    exp_t e;
    e.name = name; e.sig = sig; e.val = val; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [1:0] ty, input logic tk,
                     input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    upd_valid = 1'b1; upd_pc = pc; upd_type = ty; upd_taken = tk;
    upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
  endtask

  task automatic idle();
    upd_valid = 1'b0;
    clear = 1'b0;
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic h,
                      input logic t, input logic [31:0] tgt);
    if_pc = pc;
    chk({name, "_hit"}, S_HIT, {31'd0, h});
    chk({name, "_taken"}, S_TAKEN, {31'd0, t});
    chk({name, "_target"}, S_TARGET, tgt);
  endtask

  task automatic resolve(input string name, input logic m, input logic [31:0] r);
    chk({name, "_misp"}, S_MISP, {31'd0, m});
    chk({name, "_redir"}, S_REDIR, r);
  endtask

  task automatic stats(input string name, input logic [31:0] c, input logic [31:0] m);
    chk({name, "_ctrl"}, S_CTRL, c);
    chk({name, "_miss"}, S_MISS, m);
  endtask

  initial begin
    // Reset state
    step();
    look("rst", 32'h100, 1'b0, 1'b0, 32'h0);
    stats("rst", 32'd0, 32'd0);
    chk("rst_sat_miss", S_SAT_MISS, 32'hFFFF_FFFE);
    @(negedge clk); #2; rst = 1'b1;

    // Cold taken branch allocates; same-cycle lookup sees the old (empty) entry
    step(); upd(32'h100, 2'd0, 1'b1, 32'h80, 1'b0, 32'h0);
    look("a", 32'h100, 1'b0, 1'b0, 32'h0);
    resolve("a", 1'b1, 32'h80);
    step(); idle();
    look("b", 32'h100, 1'b1, 1'b1, 32'h80);
    stats("b", 32'd1, 32'd1);

    // Not-taken training: 2->1->0, then holds at 0
    step(); upd(32'h100, 2'd0, 1'b0, 32'h80, 1'b1, 32'h80);
    resolve("c", 1'b1, 32'h104);
    step(); upd(32'h100, 2'd0, 1'b0, 32'h80, 1'b0, 32'h0);
    look("d", 32'h100, 1'b1, 1'b0, 32'h80);
    resolve("d", 1'b0, 32'h104);
    step(); upd(32'h100, 2'd0, 1'b0, 32'h80, 1'b0, 32'h0);
    step(); upd(32'h100, 2'd0, 1'b0, 32'h80, 1'b0, 32'h0);
    resolve("f", 1'b0, 32'h104);
    step(); idle();
    look("g", 32'h100, 1'b1, 1'b0, 32'h80);
    stats("g", 32'd5, 32'd2);
    chk("g_sat_ctrl", S_SAT_CTRL, 32'hFFFF_FFFF);
    chk("g_sat_miss", S_SAT_MISS, 32'hFFFF_FFFF);

    // One taken from 0 lands on 1: still predicts not-taken
    step(); upd(32'h100, 2'd0, 1'b1, 32'h80, 1'b0, 32'h80);
    resolve("h", 1'b1, 32'h80);
    step(); upd(32'h140, 2'd1, 1'b1, 32'h200, 1'b0, 32'h0);
    look("i", 32'h100, 1'b1, 1'b0, 32'h80);
    resolve("i", 1'b1, 32'h200);

    // jal at 0x140 evicted 0x100 (same index)
    step(); idle();
    look("j", 32'h100, 1'b0, 1'b0, 32'h0);
    step();
    look("k", 32'h140, 1'b1, 1'b1, 32'h200);
    stats("k", 32'd7, 32'd4);

    // jalr hitting the entry invalidates it
    step(); upd(32'h140, 2'd2, 1'b1, 32'h300, 1'b1, 32'h200);
    resolve("l", 1'b1, 32'h300);
    step(); idle();
    look("m", 32'h140, 1'b0, 1'b0, 32'h0);
    stats("m", 32'd8, 32'd5);

    // Reserved type is a no-op even with mismatching prediction
    step(); upd(32'h140, 2'd3, 1'b1, 32'h700, 1'b0, 32'h0);
    chk("n_misp", S_MISP, 32'd0);
    step(); idle();
    look("o", 32'h140, 1'b0, 1'b0, 32'h0);
    stats("o", 32'd8, 32'd5);

    // PC+4 wraps; not-taken miss allocates nothing
    step(); upd(32'hFFFF_FFFC, 2'd0, 1'b0, 32'h0, 1'b1, 32'h40);
    resolve("p", 1'b1, 32'h0);
    step(); upd(32'h104, 2'd0, 1'b1, 32'h400, 1'b0, 32'h0);
    look("q", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    step(); idle();
    look("r", 32'h104, 1'b1, 1'b1, 32'h400);
    stats("r", 32'd10, 32'd7);

    // Clear alone: entries gone, stats kept
    clear = 1'b1;
    step(); idle();
    look("s", 32'h104, 1'b0, 1'b0, 32'h0);
    stats("s", 32'd10, 32'd7);

    // Clear wins over a same-cycle update
    step(); upd(32'h108, 2'd0, 1'b1, 32'h500, 1'b0, 32'h0); clear = 1'b1;
    step(); idle();
    look("t", 32'h108, 1'b0, 1'b0, 32'h0);

    // Async reset mid-update
    step(); upd(32'h10C, 2'd1, 1'b1, 32'h600, 1'b0, 32'h0);
    step(); idle();
    look("u", 32'h10C, 1'b1, 1'b1, 32'h600);
    step(); upd(32'h110, 2'd1, 1'b1, 32'h680, 1'b0, 32'h0);
    #1; rst = 1'b0;
    look("v", 32'h10C, 1'b0, 1'b0, 32'h0);
    stats("v", 32'd0, 32'd0);
    resolve("v", 1'b1, 32'h680);
    chk("v_sat_miss", S_SAT_MISS, 32'hFFFF_FFFE);
    step(); idle();
    #1; rst = 1'b1;
    look("w", 32'h110, 1'b0, 1'b0, 32'h0);
    stats("w", 32'd0, 32'd0);
    step();
    look("x", 32'h10C, 1'b0, 1'b0, 32'h0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      n_tests += exp_q.size();
      n_fail  += exp_q.size();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
